// File: rtl/uart_tx.sv
//------------------------------------------------------------------------------
// Module      : uart_tx
// Description : UART transmitter with a small input FIFO. Words arrive via a
//               valid/ready handshake and leave LSB-first as start bit, data,
//               optional even parity and one or two stop bits.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx #(
    parameter int BAUD_DIV      = 434,
    parameter int DATA_BITS     = 8,
    parameter int ENABLE_PARITY = 1,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int STOP_LEN = STOP_BITS * BAUD_DIV;
    localparam int BAUD_W   = $clog2(STOP_LEN);
    localparam int BIT_W    = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(STOP_LEN - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

    logic                 w_push;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_head;

    // Ready depends only on the registered occupancy, so no input reaches it.
    assign ready_out  = (count_q != FULL_CNT);
    assign w_push     = valid_in && ready_out;
    assign w_head     = mem_q[rd_ptr_q];
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

    // Frame sequencer: next state, baud/bit counters, shifter and line value.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        w_pop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    w_pop = 1'b1;
                end
            end
            ST_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        if (ENABLE_PARITY != 0) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                // Stop time spans all stop bits in one count.
                if (baud_q == STOP_LAST) begin
                    baud_d = '0;
                    if (count_q != '0) begin
                        w_pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // A pop starts the next frame on the same edge (start bit driven now).
        if (w_pop) begin
            shift_d = w_head;
            par_d   = ^w_head;
            tx_d    = 1'b0;
            state_d = ST_START;
            baud_d  = '0;
            bit_d   = '0;
        end
    end

    // FIFO pointer and occupancy update, plus the registered busy flag.
    always_comb begin
        wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        busy_d = (state_d != ST_IDLE) || (count_d != '0);
    end

    // State and control registers; reset aborts any frame and flushes the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

`default_nettype wire
